// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, FSM states and frame builder
package uart_pkg;
  localparam int FRAME_BITS = 11;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  typedef enum logic [1:0] {IDLE, SHIFT, NEXT} state_t;
  // bit 0 goes out first: start, d0..d7, even parity, stop
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] b);
    return {STOP_BIT, ^b, b, START_BIT};
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter, ticks on the last cycle of each bit
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);
  logic [DIV_WIDTH-1:0] count;
  assign tick = !clear && count == div;
  always_ff @(posedge clk)
    if (rst || clear || tick) count <= '0;
    else count <= count + 1'b1;
endmodule

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: splits a packet into bytes and shifts each out as an 11-bit UART frame
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int PACKET_SIZE = 32,
  parameter int DIV_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PACKET_SIZE-1:0] packet,
  input  logic                   packet_valid,
  output logic                   packet_ready,
  input  logic [DIV_WIDTH-1:0]   baud_div,
  input  logic                   abort,
  output logic                   tx,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   packet_done
);
  localparam int NB = PACKET_SIZE / 8;
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  state_t state, state_n;
  logic [PACKET_SIZE-1:0] pkt;
  logic [DIV_WIDTH-1:0] div;
  logic [IW-1:0] byte_idx;
  logic [3:0] bit_cnt;
  logic [FRAME_BITS-1:0] frame;
  logic aborted, tick, accept, last, frame_end;
  assign accept = packet_valid && packet_ready;
  assign last = byte_idx == IW'(NB - 1);
  assign frame_end = tick && bit_cnt == 4'(FRAME_BITS - 1);
  assign frame = build_frame(pkt[8*byte_idx +: 8]);
  uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) baud (
    .clk(clk),
    .rst(rst),
    .clear(state != SHIFT),
    .div(div),
    .tick(tick)
  );
  always_comb begin
    state_n = state;
    packet_ready = state == IDLE && !rst;
    busy = state != IDLE;
    tx = state == SHIFT ? frame[bit_cnt] : 1'b1;
    frame_done = state == NEXT;
    packet_done = state == NEXT && (last || aborted);
    state_n = state == IDLE  ? (accept ? SHIFT : IDLE) :
              state == SHIFT ? (frame_end ? NEXT : SHIFT) :
                               ((last || aborted) ? IDLE : SHIFT);
  end
  // abort is only honoured between frames, so the flag lives until IDLE is re-entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pkt <= '0;
      div <= '0;
      byte_idx <= '0;
      bit_cnt <= '0;
      aborted <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        pkt <= packet;
        div <= baud_div;
      end
      byte_idx <= state == IDLE ? '0 : (state == NEXT && state_n == SHIFT) ? byte_idx + 1'b1 : byte_idx;
      bit_cnt <= (state != SHIFT || frame_end) ? '0 : tick ? bit_cnt + 1'b1 : bit_cnt;
      aborted <= state != IDLE && state_n != IDLE && (aborted || abort);
    end
  end
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer: scoreboard-based check of 8/16/32-bit sequencer instances
module tb_uart_tx_sequencer;
  typedef struct {logic [7:0] b; int div;} exp_t;
  typedef struct {int sel; logic [31:0] pkt; int div; bit pre_abort; int abort_at; int busy; int frames;} vec_t;
  logic clk = 0, rst;
  logic [31:0] packet [3];
  logic [15:0] baud_div [3];
  logic [2:0] packet_valid, packet_ready, abort, tx, busy, frame_done, packet_done;
  int sel, cmp = 0, bad = 0, frames = 0, fd_cnt = 0, pd_cnt = 0;
  exp_t sb[$];
  exp_t e;
  bit in_frame = 0, want_fd = 0;
  int per, cyc, glitch;
  logic [10:0] got, want;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx_sequencer #(.PACKET_SIZE(8 << g), .DIV_WIDTH(16)) dut (
      .clk(clk),
      .rst(rst),
      .packet(packet[g][(8<<g)-1:0]),
      .packet_valid(packet_valid[g]),
      .packet_ready(packet_ready[g]),
      .baud_div(baud_div[g]),
      .abort(abort[g]),
      .tx(tx[g]),
      .busy(busy[g]),
      .frame_done(frame_done[g]),
      .packet_done(packet_done[g])
    );
  end
  task automatic chk(string name, int act, int exp);
    cmp++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic push(logic [31:0] p, int d, int n);
    for (int k = 0; k < n; k++) sb.push_back('{p[8*k +: 8], d});
  endtask
  task automatic send(int s, logic [31:0] p, int d, int nexp);
    int t = 0;
    @(negedge clk);
    packet[s] = p;
    baud_div[s] = 16'(d);
    packet_valid[s] = 1;
    push(p, d, nexp);
    while (!packet_ready[s] && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait", int'(t < 1000), 1);
    @(posedge clk);
    #1;
    packet_valid[s] = 0;
    abort[s] = 0;
  endtask
  task automatic wait_idle(int s, int abort_at, output int bc);
    bc = 0;
    @(negedge clk);
    while (busy[s] && bc < 20000) begin
      abort[s] = bc == abort_at;
      bc++;
      @(negedge clk);
    end
    abort[s] = 0;
  endtask
  // frame decoder: samples tx every cycle, checks bit hold times and the contents
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 0;
      want_fd = 0;
    end else begin
      if (frame_done[sel]) fd_cnt++;
      if (packet_done[sel]) pd_cnt++;
      if (want_fd) begin
        chk("frame_done", int'(frame_done[sel]), 1);
        chk("gap_tx", int'(tx[sel]), 1);
        want_fd = 0;
      end else if (!in_frame && !tx[sel]) begin
        chk("start_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          per = e.div + 1;
          want = {1'b1, ^e.b, e.b, 1'b0};
          got = '0;
          glitch = 0;
          cyc = 0;
          in_frame = 1;
        end
      end
      if (in_frame) begin
        if (cyc % per == 0) got[cyc/per] = tx[sel];
        else if (got[cyc/per] != tx[sel]) glitch++;
        cyc++;
        if (cyc == 11 * per) begin
          chk("frame", int'(got), int'(want));
          chk("bit_hold", glitch, 0);
          in_frame = 0;
          want_fd = 1;
          frames++;
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t v [7];
    int bc, f0, p0, d0, n;
    v[0] = '{1, 32'h0000A55A, 3, 0, -1, 90, 2};
    v[1] = '{0, 32'h00000007, 0, 0, -1, 12, 1};
    v[2] = '{2, 32'h12345678, 1, 0, -1, 92, 4};
    v[3] = '{0, 32'h000000FF, 2, 0, -1, 34, 1};
    v[4] = '{1, 32'h00000000, 0, 0, -1, 24, 2};
    v[5] = '{2, 32'h11223344, 1, 0, 5, 23, 1};
    v[6] = '{2, 32'hCAFEF00D, 0, 1, -1, 48, 4};
    rst = 1;
    sel = 0;
    packet_valid = '0;
    abort = '0;
    for (int g = 0; g < 3; g++) begin
      packet[g] = '0;
      baud_div[g] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx), 7);
    chk("rst_ready", int'(packet_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'({frame_done, packet_done}), 0);
    rst = 0;
    #1 chk("ready_after_rst", int'(packet_ready), 7);
    foreach (v[i]) begin
      sel = v[i].sel;
      f0 = frames;
      p0 = pd_cnt;
      d0 = fd_cnt;
      abort[sel] = v[i].pre_abort;
      if (v[i].pre_abort) repeat (3) @(negedge clk);
      send(sel, v[i].pkt, v[i].div, v[i].frames);
      wait_idle(sel, v[i].abort_at, bc);
      chk("busy_cycles", bc, v[i].busy);
      chk("frames", frames - f0, v[i].frames);
      chk("frame_done_cnt", fd_cnt - d0, v[i].frames);
      chk("packet_done_cnt", pd_cnt - p0, 1);
      chk("ready_idle", int'(packet_ready[sel]), 1);
      n = 0;
      repeat (10) begin
        @(negedge clk);
        n += int'(!tx[sel]);
      end
      chk("quiet_tx", n, 0);
      chk("sb_empty", sb.size(), 0);
    end
    // reset in the middle of bit 5 of frame 0
    sel = 1;
    f0 = frames;
    p0 = pd_cnt;
    d0 = fd_cnt;
    send(1, 32'hA55A, 3, 2);
    repeat (22) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_tx", int'(tx[1]), 1);
    chk("rst_mid_busy", int'(busy[1]), 0);
    chk("rst_mid_ready", int'(packet_ready[1]), 0);
    rst = 0;
    sb.delete();
    #1 chk("rst_mid_ready_after", int'(packet_ready[1]), 1);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      n += int'(!tx[1]);
    end
    chk("rst_mid_quiet", n, 0);
    chk("rst_mid_pulses", fd_cnt - d0 + pd_cnt - p0, 0);
    chk("rst_mid_frames", frames - f0, 0);
    // valid held with a second packet and baud_div changed while the first is in flight
    f0 = frames;
    p0 = pd_cnt;
    send(1, 32'h1234, 2, 2);
    packet[1] = 32'hBEEF;
    baud_div[1] = 0;
    packet_valid[1] = 1;
    push(32'hBEEF, 0, 2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!packet_ready[1] && n < 1000);
    chk("b2b_wait", n, 69);
    @(posedge clk);
    #1 packet_valid[1] = 0;
    wait_idle(1, -1, bc);
    chk("b2b_busy", bc, 24);
    chk("b2b_frames", frames - f0, 4);
    chk("b2b_packet_done", pd_cnt - p0, 2);
    chk("b2b_sb_empty", sb.size(), 0);
    // parity sweep over every byte value
    sel = 0;
    f0 = frames;
    for (int b = 0; b < 256; b++) begin
      send(0, 32'(b), 0, 1);
      wait_idle(0, -1, bc);
    end
    chk("sweep_frames", frames - f0, 256);
    chk("sweep_sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
